// File: rtl/md_unit_if.sv
// md_unit_if: execute-stage request/response bundle between the pipeline and the
// multiply/divide sequencer. The master side is the pipeline, the slave side is
// md_unit_ctrl. The md_cancel line exists only when MD_CANCEL_EN is defined.
interface md_unit_if;
  logic        mdstart;
  logic [2:0]  mdop;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hlwrite;
  logic        hlsel;
  logic        d_md_use;
`ifdef MD_CANCEL_EN
  logic        md_cancel;
`endif
  logic [31:0] hl_rdata;
  logic        busy;
  logic        stall_md;

  modport master (
    output mdstart,
    output mdop,
    output src_a,
    output src_b,
    output hlwrite,
    output hlsel,
    output d_md_use,
`ifdef MD_CANCEL_EN
    output md_cancel,
`endif
    input  hl_rdata,
    input  busy,
    input  stall_md
  );

  modport slave (
    input  mdstart,
    input  mdop,
    input  src_a,
    input  src_b,
    input  hlwrite,
    input  hlsel,
    input  d_md_use,
`ifdef MD_CANCEL_EN
    input  md_cancel,
`endif
    output hl_rdata,
    output busy,
    output stall_md
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: execute-stage multiply/divide sequencer. Owns HI/LO, runs
// mult/multu/div/divu as a fixed-length busy window (result is computed at the
// start edge and parked in pending registers, then committed on the last busy
// edge), services mfhi/mflo/mthi/mtlo and raises stall_md toward the hazard unit.
// Optional feature: define MD_CANCEL_EN to add md_cancel, which aborts an
// in-flight operation (no commit) or suppresses a start in IDLE.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_commit_q, pend_commit_d;

  logic               cancel;
  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic               div_signed;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag;
  logic [31:0]        q_mag, r_mag;
  logic [31:0]        quot, rem;
  logic               div_by_zero;

`ifdef MD_CANCEL_EN
  assign cancel = md.md_cancel;
`else
  assign cancel = 1'b0;
`endif

  // Arithmetic datapath: products and a sign-magnitude divider, so the
  // 0x80000000 / -1 corner stays well defined (quotient wraps to 0x80000000).
  always_comb begin
    mul_s       = $signed({{32{md.src_a[31]}}, md.src_a}) *
                  $signed({{32{md.src_b[31]}}, md.src_b});
    mul_u       = {32'd0, md.src_a} * {32'd0, md.src_b};
    div_signed  = (md.mdop == 3'd2);
    a_neg       = div_signed & md.src_a[31];
    b_neg       = div_signed & md.src_b[31];
    a_mag       = a_neg ? (~md.src_a + 32'd1) : md.src_a;
    b_mag       = b_neg ? (~md.src_b + 32'd1) : md.src_b;
    div_by_zero = (md.src_b == 32'd0);
    q_mag       = 32'd0;
    r_mag       = 32'd0;
    if (!div_by_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state logic: start/accept in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    pend_hi_d     = pend_hi_q;
    pend_lo_d     = pend_lo_q;
    pend_commit_d = pend_commit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (md.mdstart) begin
          // mdstart always wins over hlwrite, even when the op is reserved
          // or the start is cancelled.
          if (!md.mdop[2] && !cancel) begin
            state_d = ST_BUSY;
            if (md.mdop[1]) begin
              cnt_d         = CNT_W'(DIV_CYCLES);
              pend_hi_d     = rem;
              pend_lo_d     = quot;
              pend_commit_d = !div_by_zero;
            end else begin
              cnt_d         = CNT_W'(MULT_CYCLES);
              pend_hi_d     = md.mdop[0] ? mul_u[63:32] : mul_s[63:32];
              pend_lo_d     = md.mdop[0] ? mul_u[31:0]  : mul_s[31:0];
              pend_commit_d = 1'b1;
            end
          end
        end else if (md.hlwrite) begin
          if (md.hlsel) begin
            hi_d = md.src_a;
          end else begin
            lo_d = md.src_a;
          end
        end
      end

      ST_BUSY: begin
        // New starts and HI/LO writes are ignored while busy.
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      pend_hi_q     <= 32'd0;
      pend_lo_q     <= 32'd0;
      pend_commit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      pend_commit_q <= pend_commit_d;
    end
  end

  assign md.busy     = (state_q == ST_BUSY);
  assign md.hl_rdata = md.hlsel ? hi_q : lo_q;
  assign md.stall_md = md.d_md_use & (md.mdstart | md.busy);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed bench for md_unit_ctrl. Inputs change and outputs
// are sampled on the falling clock edge; each scenario is one task.
module tb_md_unit_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  md_unit_if bus_if ();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus_if)
  );

  // Start an operation, then count busy cycles (bounded) until busy drops.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = op;
    bus_if.src_a   = a;
    bus_if.src_b   = b;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    @(negedge clk);
    bus_if.hlwrite = 1'b1;
    bus_if.hlsel   = sel;
    bus_if.src_a   = v;
    @(negedge clk);
    bus_if.hlwrite = 1'b0;
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    bus_if.hlsel = sel;
    #1;
    v = bus_if.hl_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_if.d_md_use = 1'b1;
    #1;
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    total++;
    if (bus_if.stall_md !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus_if.stall_md); end
    bus_if.d_md_use = 1'b0;
    rd(1'b0, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", v); end
    rd(1'b1, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", v); end
    $display("reset: busy=%b lo/hi checked", bus_if.busy);
  endtask

  task automatic test_mult;
    int n;
    logic [31:0] hi, lo;
    start_op(3'd0, 32'd3, 32'hFFFF_FFFC, n);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (n != 5) begin bad++; $display("FAIL mult_cycles got=%0d exp=5", n); end
    total++;
    if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++;
    if (lo !== 32'hFFFF_FFF4) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff4", lo); end
    $display("mult 3*-4: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_multu;
    int n;
    logic [31:0] hi, lo;
    start_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (n != 5) begin bad++; $display("FAIL multu_cycles got=%0d exp=5", n); end
    total++;
    if (hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    total++;
    if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    $display("multu ffffffff*2: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_div;
    int n;
    logic [31:0] hi, lo;
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (n != 10) begin bad++; $display("FAIL div_cycles got=%0d exp=10", n); end
    total++;
    if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    total++;
    if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    $display("div -7/2: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_divu;
    int n;
    logic [31:0] hi, lo;
    start_op(3'd3, 32'd7, 32'd2, n);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (n != 10) begin bad++; $display("FAIL divu_cycles got=%0d exp=10", n); end
    total++;
    if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
    total++;
    if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    $display("divu 7/2: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_div_zero;
    int n;
    logic [31:0] hi, lo;
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    start_op(3'd2, 32'd5, 32'd0, n);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (n != 10) begin bad++; $display("FAIL divzero_cycles got=%0d exp=10", n); end
    total++;
    if (hi !== 32'h11) begin bad++; $display("FAIL divzero_hi got=%h exp=00000011", hi); end
    total++;
    if (lo !== 32'h22) begin bad++; $display("FAIL divzero_lo got=%h exp=00000022", lo); end
    $display("div 5/0: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_stall;
    @(negedge clk);
    bus_if.d_md_use = 1'b1;
    bus_if.mdstart  = 1'b1;
    bus_if.mdop     = 3'd0;
    bus_if.src_a    = 32'd1;
    bus_if.src_b    = 32'd1;
    #1;
    total++;
    if (bus_if.stall_md !== 1'b1) begin bad++; $display("FAIL stall_start got=%b exp=1", bus_if.stall_md); end
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus_if.stall_md !== 1'b1) begin
        bad++; $display("FAIL stall_busy%0d got=%b exp=1", i, bus_if.stall_md);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (bus_if.stall_md !== 1'b0) begin bad++; $display("FAIL stall_after got=%b exp=0", bus_if.stall_md); end
    bus_if.d_md_use = 1'b0;
    // Start without a dependent D-stage instruction: no stall.
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    #1;
    total++;
    if (bus_if.stall_md !== 1'b0) begin bad++; $display("FAIL stall_nouse got=%b exp=0", bus_if.stall_md); end
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    for (int i = 0; i < 20 && bus_if.busy === 1'b1; i++) @(negedge clk);
    $display("stall: start cycle plus 5 busy cycles checked");
  endtask

  task automatic test_mthi;
    logic [31:0] hi, lo;
    mt(1'b0, 32'h55);
    mt(1'b1, 32'h1234);
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h exp=00001234", hi); end
    total++;
    if (lo !== 32'h55) begin bad++; $display("FAIL mthi_lo got=%h exp=00000055", lo); end
    $display("mthi 1234: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reserved;
    logic [31:0] hi, lo;
    mt(1'b1, 32'h77);
    mt(1'b0, 32'h88);
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = 3'd5;
    bus_if.src_a   = 32'd9;
    bus_if.src_b   = 32'd9;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    #1;
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reserved_busy got=%b exp=0", bus_if.busy); end
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (hi !== 32'h77 || lo !== 32'h88) begin
      bad++; $display("FAIL reserved_hilo got=%h/%h exp=00000077/00000088", hi, lo);
    end
    $display("reserved op 5: busy=%b hi=%h lo=%h", bus_if.busy, hi, lo);
  endtask

  task automatic test_start_hlwrite;
    int n;
    logic [31:0] hi, lo;
    mt(1'b0, 32'hAAAA);
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = 3'd0;
    bus_if.src_a   = 32'd2;
    bus_if.src_b   = 32'd3;
    bus_if.hlwrite = 1'b1;
    bus_if.hlsel   = 1'b0;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    bus_if.hlwrite = 1'b0;
    rd(1'b0, lo);
    total++;
    if (lo !== 32'hAAAA) begin bad++; $display("FAIL start_hlw_drop got=%h exp=0000aaaa", lo); end
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    rd(1'b0, lo);
    rd(1'b1, hi);
    total++;
    if (n != 5 || lo !== 32'd6 || hi !== 32'd0) begin
      bad++; $display("FAIL start_hlw_result got=%0d/%h/%h exp=5/00000000/00000006", n, hi, lo);
    end
    $display("mdstart+hlwrite: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_busy_ignore;
    int n;
    logic [31:0] hi, lo;
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = 3'd0;
    bus_if.src_a   = 32'd4;
    bus_if.src_b   = 32'd5;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      // Inject a start and an mthi on the second busy cycle; both must be ignored.
      bus_if.mdstart = (n == 1);
      bus_if.hlwrite = (n == 1);
      bus_if.mdop    = 3'd2;
      bus_if.src_a   = 32'hDEAD;
      bus_if.src_b   = 32'd7;
      bus_if.hlsel   = 1'b1;
      n++;
      @(negedge clk);
    end
    bus_if.mdstart = 1'b0;
    bus_if.hlwrite = 1'b0;
    #1;
    total++;
    if (n != 5 || bus_if.busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore_cycles got=%0d busy=%b exp=5 busy=0", n, bus_if.busy);
    end
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (hi !== 32'd0 || lo !== 32'd20) begin
      bad++; $display("FAIL busy_ignore_hilo got=%h/%h exp=00000000/00000014", hi, lo);
    end
    $display("busy ignore: cycles=%0d hi=%h lo=%h", n, hi, lo);
  endtask

  task automatic test_reset_mid;
    logic [31:0] hi, lo;
    mt(1'b1, 32'h33);
    mt(1'b0, 32'h44);
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = 3'd2;
    bus_if.src_a   = 32'd100;
    bus_if.src_b   = 32'd3;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL resetmid_busy got=%b exp=0", bus_if.busy); end
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL resetmid_hilo got=%h/%h exp=00000000/00000000", hi, lo);
    end
    repeat (12) @(negedge clk);
    rd(1'b0, lo);
    total++;
    if (lo !== 32'd0 || bus_if.busy !== 1'b0) begin
      bad++; $display("FAIL resetmid_nocommit got=%h busy=%b exp=00000000 busy=0", lo, bus_if.busy);
    end
    $display("reset mid-div: busy=%b hi=%h lo=%h", bus_if.busy, hi, lo);
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel;
    logic [31:0] hi, lo;
    mt(1'b1, 32'h66);
    mt(1'b0, 32'h99);
    @(negedge clk);
    bus_if.mdstart = 1'b1;
    bus_if.mdop    = 3'd1;
    bus_if.src_a   = 32'd10;
    bus_if.src_b   = 32'd10;
    @(negedge clk);
    bus_if.mdstart = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.md_cancel = 1'b1;
    @(negedge clk);
    bus_if.md_cancel = 1'b0;
    #1;
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", bus_if.busy); end
    rd(1'b1, hi);
    rd(1'b0, lo);
    total++;
    if (hi !== 32'h66 || lo !== 32'h99) begin
      bad++; $display("FAIL cancel_hilo got=%h/%h exp=00000066/00000099", hi, lo);
    end
    @(negedge clk);
    bus_if.mdstart   = 1'b1;
    bus_if.md_cancel = 1'b1;
    @(negedge clk);
    bus_if.mdstart   = 1'b0;
    bus_if.md_cancel = 1'b0;
    #1;
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL cancel_start got=%b exp=0", bus_if.busy); end
    $display("cancel: busy=%b hi=%h lo=%h", bus_if.busy, hi, lo);
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus_if.mdstart  = 1'b0;
    bus_if.mdop     = 3'd0;
    bus_if.src_a    = 32'd0;
    bus_if.src_b    = 32'd0;
    bus_if.hlwrite  = 1'b0;
    bus_if.hlsel    = 1'b0;
    bus_if.d_md_use = 1'b0;
`ifdef MD_CANCEL_EN
    bus_if.md_cancel = 1'b0;
`endif
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_div_zero();
    test_stall();
    test_mthi();
    test_reserved();
    test_start_hlwrite();
    test_busy_ignore();
    test_reset_mid();
`ifdef MD_CANCEL_EN
    test_cancel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
